// File: rtl/trigger_fft_sequencer_pkg.sv
// Shared constants, sample packing, FSM states and address helper
// for the trigger FFT sequencer.
package trigger_fft_sequencer_pkg;

    localparam int FFT_N_POINTS = 64;
    localparam int FFT_ADDR_W   = 6;

    // Complex sample packing: {im, re}, both signed
    localparam int RE_LSB   = 0;
    localparam int IM_LSB   = 16;
    localparam int SAMPLE_W = 16;
    localparam int POWER_W  = 33;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREFETCH,
        ST_STREAM,
        ST_COLLECT,
        ST_DONE
    } state_t;

    function automatic logic [FFT_ADDR_W-1:0] bit_reverse(
        input logic [FFT_ADDR_W-1:0] a
    );
        logic [FFT_ADDR_W-1:0] r;
        for (int i = 0; i < FFT_ADDR_W; i++) begin
            r[i] = a[FFT_ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/trigger_fft_sequencer_bin_power.sv
// Registered power of one complex bin: re*re + im*im, 33-bit unsigned.
// Ports: clk, reset_b, valid (capture strobe), sample {im,re}, power (held).
module bin_power
    import trigger_fft_sequencer_pkg::*;
(
    input  logic               clk,
    input  logic               reset_b,
    input  logic               valid,
    input  logic [31:0]        sample,
    output logic [POWER_W-1:0] power
);

    logic signed [SAMPLE_W-1:0] re;
    logic signed [SAMPLE_W-1:0] im;
    logic signed [31:0]         re_sq;
    logic signed [31:0]         im_sq;
    logic [POWER_W-1:0]         sum;

    assign re = sample[RE_LSB +: SAMPLE_W];
    assign im = sample[IM_LSB +: SAMPLE_W];

    // Each square is at most 2^30, so 32-bit signed holds it exactly
    assign re_sq = 32'(re) * 32'(re);
    assign im_sq = 32'(im) * 32'(im);
    assign sum   = {1'b0, re_sq} + {1'b0, im_sq};

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            power <= '0;
        end else if (valid) begin
            power <= sum;
        end
    end

endmodule

// File: rtl/trigger_fft_sequencer.sv
// Runs one trigger FFT per frame: RAM -> xfft input stream, output bins
// -> target-bin power -> threshold trigger. Ports: frame/config control,
// RAM read port, FFT slave/master streams, status and trigger outputs.
module trigger_fft_sequencer
    import trigger_fft_sequencer_pkg::*;
#(
    parameter int N_POINTS    = FFT_N_POINTS,
    parameter int ADDR_W      = FFT_ADDR_W,
    parameter int TARGET_BIN  = 10,
    parameter int BIT_REVERSE = 1
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              FFT_Configure_Complete,
    input  logic              Frame_Ready,
    input  logic [32:0]       Threshold,
    output logic [ADDR_W-1:0] RAM_Read_Address,
    input  logic [31:0]       RAM_Data,
    output logic [31:0]       FFT_S_tdata,
    output logic              FFT_S_tvalid,
    input  logic              FFT_S_tready,
    output logic              FFT_S_tlast,
    input  logic [31:0]       FFT_M_tdata,
    input  logic              FFT_M_tvalid,
    input  logic              FFT_M_tlast,
    output logic              FFT_M_tready,
    output logic              Busy,
    output logic              Trigger,
    output logic [32:0]       Target_Power,
    output logic              Frame_Dropped,
    output logic              Sync_Error
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_POINTS - 1);
    localparam logic [ADDR_W-1:0] TGT_IDX  = ADDR_W'(TARGET_BIN);

    state_t            state_q;
    state_t            state_d;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] bin_q;
    logic [ADDR_W-1:0] nxt_idx;
    logic [32:0]       thr_q;
    logic              pending_q;
    logic              drop_q;
    logic              sync_err_q;
    logic              abort_q;
    logic              start;
    logic              s_hs;
    logic              m_hs;
    logic              bin_last;
    logic              early_last;
    logic              power_vld;

    assign start = (state_q == ST_IDLE) && FFT_Configure_Complete
                 && (Frame_Ready || pending_q);
    assign s_hs       = (state_q == ST_STREAM) && FFT_S_tready;
    assign m_hs       = (state_q == ST_COLLECT) && FFT_M_tvalid;
    assign bin_last   = (bin_q == LAST_IDX);
    assign early_last = m_hs && FFT_M_tlast && !bin_last;
    assign power_vld  = m_hs && (bin_q == TGT_IDX);

    // Look one sample ahead on a handshake so the 1-cycle RAM latency
    // never inserts a bubble; on a stall the address simply holds.
    assign nxt_idx = idx_q + {{(ADDR_W-1){1'b0}}, s_hs};
    assign RAM_Read_Address = (BIT_REVERSE != 0) ? bit_reverse(nxt_idx)
                                                 : nxt_idx;

    assign Frame_Dropped = drop_q;
    assign Sync_Error    = sync_err_q;

    bin_power u_bin_power (
        .clk     (clk),
        .reset_b (reset_b),
        .valid   (power_vld),
        .sample  (FFT_M_tdata),
        .power   (Target_Power)
    );

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:     if (start) state_d = ST_PREFETCH;
            ST_PREFETCH: state_d = ST_STREAM;
            ST_STREAM: begin
                if (s_hs && idx_q == LAST_IDX) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                if (m_hs && (bin_last || FFT_M_tlast)) state_d = ST_DONE;
            end
            ST_DONE:     state_d = ST_IDLE;
            default:     state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        Busy         = (state_q != ST_IDLE);
        FFT_S_tvalid = 1'b0;
        FFT_S_tdata  = '0;
        FFT_S_tlast  = 1'b0;
        FFT_M_tready = 1'b0;
        Trigger      = 1'b0;
        unique case (state_q)
            ST_STREAM: begin
                FFT_S_tvalid = 1'b1;
                FFT_S_tdata  = RAM_Data;
                FFT_S_tlast  = (idx_q == LAST_IDX);
            end
            ST_COLLECT: FFT_M_tready = 1'b1;
            ST_DONE:    Trigger = !abort_q && (Target_Power > thr_q);
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_b) begin
        if (!reset_b) begin
            idx_q      <= '0;
            bin_q      <= '0;
            thr_q      <= '0;
            pending_q  <= 1'b0;
            drop_q     <= 1'b0;
            sync_err_q <= 1'b0;
            abort_q    <= 1'b0;
        end else begin
            drop_q <= Frame_Ready && pending_q;
            if (start) begin
                thr_q     <= Threshold;
                pending_q <= 1'b0;
                idx_q     <= '0;
                bin_q     <= '0;
                abort_q   <= 1'b0;
            end else begin
                if (Frame_Ready) pending_q <= 1'b1;
                // idx wraps to 0 on the final beat of the frame
                if (s_hs) idx_q <= idx_q + 1'b1;
                if (m_hs) bin_q <= bin_q + 1'b1;
                if (early_last) abort_q <= 1'b1;
            end
            if (early_last || (m_hs && bin_last && !FFT_M_tlast)) begin
                sync_err_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_trigger_fft_sequencer.sv
// Self-checking bench for trigger_fft_sequencer: scoreboarded input
// stream, directed bin injection, trigger, pending, gating and reset.
module tb_trigger_fft_sequencer;

    logic        clk = 1'b0;
    logic        reset_b;
    logic        cfg;
    logic        Frame_Ready;
    logic [32:0] Threshold;
    logic [5:0]  RAM_Read_Address;
    logic [31:0] RAM_Data;
    logic [31:0] FFT_S_tdata;
    logic        FFT_S_tvalid;
    logic        FFT_S_tready;
    logic        FFT_S_tlast;
    logic [31:0] FFT_M_tdata;
    logic        FFT_M_tvalid;
    logic        FFT_M_tlast;
    logic        FFT_M_tready;
    logic        Busy;
    logic        Trigger;
    logic [32:0] Target_Power;
    logic        Frame_Dropped;
    logic        Sync_Error;

    int checks = 0;
    int failures = 0;
    int drop_cnt = 0;
    int k = 0;
    bit rand_rdy = 1'b0;

    logic [31:0] mem [64];
    logic [31:0] exp_data [$];
    logic        exp_last [$];

    always #5 clk = ~clk;

    trigger_fft_sequencer dut (
        .clk                    (clk),
        .reset_b                (reset_b),
        .FFT_Configure_Complete (cfg),
        .Frame_Ready            (Frame_Ready),
        .Threshold              (Threshold),
        .RAM_Read_Address       (RAM_Read_Address),
        .RAM_Data               (RAM_Data),
        .FFT_S_tdata            (FFT_S_tdata),
        .FFT_S_tvalid           (FFT_S_tvalid),
        .FFT_S_tready           (FFT_S_tready),
        .FFT_S_tlast            (FFT_S_tlast),
        .FFT_M_tdata            (FFT_M_tdata),
        .FFT_M_tvalid           (FFT_M_tvalid),
        .FFT_M_tlast            (FFT_M_tlast),
        .FFT_M_tready           (FFT_M_tready),
        .Busy                   (Busy),
        .Trigger                (Trigger),
        .Target_Power           (Target_Power),
        .Frame_Dropped          (Frame_Dropped),
        .Sync_Error             (Sync_Error)
    );

    initial begin
        for (int a = 0; a < 64; a++) mem[a] = 32'(a);
    end

    // Block RAM port B: one-cycle registered read
    always @(posedge clk) RAM_Data <= mem[RAM_Read_Address];

    function automatic logic [5:0] rev6(input logic [5:0] a);
        logic [5:0] r;
        for (int i = 0; i < 6; i++) r[i] = a[5-i];
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_frame();
        for (int j = 0; j < 64; j++) begin
            exp_data.push_back(32'(rev6(6'(j))));
            exp_last.push_back(j == 63);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_fr();
        Frame_Ready = 1'b1;
        wait_cycles(1);
        Frame_Ready = 1'b0;
    endtask

    // Stalls at #2 so they never race the #1 stimulus writes
    always @(posedge clk) begin
        #2;
        if (rand_rdy) FFT_S_tready = 1'($urandom_range(0, 1));
    end

    // Stream monitor: peeks while stalled, pops on handshake
    always @(negedge clk) begin
        if (!reset_b) begin
            k = 0;
        end else begin
            if (Frame_Dropped) drop_cnt++;
            if (FFT_S_tvalid) begin
                if (exp_data.size() == 0) begin
                    check("s_unexpected_beat", FFT_S_tvalid, 0);
                end else begin
                    check("s_tdata", FFT_S_tdata, exp_data[0]);
                    check("s_tlast", FFT_S_tlast, exp_last[0]);
                    check("s_addr", RAM_Read_Address,
                          rev6(FFT_S_tready ? 6'(k + 1) : 6'(k)));
                    if (FFT_S_tready) begin
                        void'(exp_data.pop_front());
                        void'(exp_last.pop_front());
                        k = (k + 1) % 64;
                    end
                end
            end
        end
    end

    task automatic collect(input int last_bin, input logic [31:0] b10,
                           input logic [32:0] thr, input int q_left);
        int n;
        longint re;
        longint im;
        logic [32:0] pw;
        bit early;
        n = 0;
        while (FFT_M_tready !== 1'b1 && n < 2000) begin
            wait_cycles(1);
            n++;
        end
        rand_rdy = 1'b0;
        FFT_S_tready = 1'b1;
        check("collect_entry", FFT_M_tready, 1);
        if (FFT_M_tready !== 1'b1) return;
        check("stream_beats_left", exp_data.size(), q_left);
        re = longint'(signed'(b10[15:0]));
        im = longint'(signed'(b10[31:16]));
        pw = 33'(re * re + im * im);
        early = (last_bin != 63);
        for (int b = 0; b <= last_bin; b++) begin
            FFT_M_tvalid = 1'b1;
            FFT_M_tdata  = (b == 10) ? b10 : $urandom;
            FFT_M_tlast  = (b == last_bin);
            wait_cycles(1);
        end
        FFT_M_tvalid = 1'b0;
        FFT_M_tlast  = 1'b0;
        check("done_busy", Busy, 1);
        check("done_trigger", Trigger, !early && (pw > thr));
        check("target_power", Target_Power, pw);
        check("sync_error", Sync_Error, early);
        wait_cycles(1);
        check("post_done_trigger", Trigger, 0);
        check("post_done_busy", Busy, 0);
    endtask

    initial begin
        int bad;
        reset_b = 1'b0;
        cfg = 1'b1;
        Frame_Ready = 1'b0;
        Threshold = '0;
        FFT_S_tready = 1'b1;
        FFT_M_tvalid = 1'b0;
        FFT_M_tdata = '0;
        FFT_M_tlast = 1'b0;
        wait_cycles(3);
        check("rst_busy", Busy, 0);
        check("rst_tvalid", FFT_S_tvalid, 0);
        check("rst_addr", RAM_Read_Address, 0);
        check("rst_trigger", Trigger, 0);
        check("rst_power", Target_Power, 0);
        check("rst_sync", Sync_Error, 0);
        check("rst_drop", Frame_Dropped, 0);
        check("rst_mready", FFT_M_tready, 0);
        reset_b = 1'b1;
        wait_cycles(1);

        // Frame A: latency, natural ready, trigger above threshold
        Threshold = 33'd249999;
        push_frame();
        pulse_fr();
        check("lat_c1_tvalid", FFT_S_tvalid, 0);
        check("lat_c1_busy", Busy, 1);
        wait_cycles(1);
        check("lat_c2_tvalid", FFT_S_tvalid, 1);
        collect(63, 32'h012C_FE70, 33'd249999, 0);

        // Frame B: random stalls, power equal to threshold
        Threshold = 33'd250000;
        rand_rdy = 1'b1;
        push_frame();
        pulse_fr();
        collect(63, 32'h012C_FE70, 33'd250000, 0);

        // Frames C+D: two requests during C, one pends, one drops
        push_frame();
        pulse_fr();
        wait_cycles(5);
        push_frame();
        pulse_fr();
        wait_cycles(3);
        pulse_fr();
        collect(63, 32'h0000_0200, 33'd250000, 64);
        collect(63, 32'hFE70_012C, 33'd250000, 0);
        check("drop_count", drop_cnt, 1);

        // Frame E: request held until configuration completes
        cfg = 1'b0;
        push_frame();
        pulse_fr();
        bad = 0;
        repeat (20) begin
            wait_cycles(1);
            if (FFT_S_tvalid !== 1'b0 || Busy !== 1'b0) bad++;
        end
        check("cfg_gate_idle", bad, 0);
        cfg = 1'b1;
        wait_cycles(1);
        check("cfg_c1_tvalid", FFT_S_tvalid, 0);
        check("cfg_c1_busy", Busy, 1);
        wait_cycles(1);
        check("cfg_c2_tvalid", FFT_S_tvalid, 1);
        collect(63, 32'h012C_FE70, 33'd250000, 0);

        // Frame F: early tlast at bin 40
        Threshold = '0;
        push_frame();
        pulse_fr();
        collect(40, 32'h0100_0100, 33'd0, 0);
        wait_cycles(5);
        check("sync_sticky", Sync_Error, 1);
        check("sync_idle", Busy, 0);

        // Frame G: asynchronous reset mid-stream
        push_frame();
        pulse_fr();
        wait_cycles(10);
        check("g_streaming", FFT_S_tvalid, 1);
        #2;
        reset_b = 1'b0;
        #1;
        check("arst_busy", Busy, 0);
        check("arst_tvalid", FFT_S_tvalid, 0);
        check("arst_tdata", FFT_S_tdata, 0);
        check("arst_addr", RAM_Read_Address, 0);
        check("arst_sync", Sync_Error, 0);
        check("arst_power", Target_Power, 0);
        check("arst_trigger", Trigger, 0);
        exp_data.delete();
        exp_last.delete();
        @(posedge clk);
        #1;
        reset_b = 1'b1;
        wait_cycles(3);
        check("post_rst_busy", Busy, 0);
        check("post_rst_tvalid", FFT_S_tvalid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
